// File: rtl/intersection_pkg.sv
// Shared types and timing defaults for the intersection phase scheduler.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package intersection_pkg;

  // Default phase timing, in clock cycles
  localparam int unsigned DEF_MIN_GREEN = 4;
  localparam int unsigned DEF_MAX_GREEN = 12;
  localparam int unsigned DEF_YELLOW_T  = 3;
  localparam int unsigned DEF_ALL_RED_T = 1;
  localparam int unsigned DEF_WALK_T    = 6;

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned PHASE_W = 3;

  // The enum values are the external phase encoding; 6 and 7 are unused
  typedef enum logic [PHASE_W-1:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED   = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } state_t;

  // Which service phase was entered most recently
  typedef enum logic [1:0] {
    SRV_NS  = 2'd0,
    SRV_EW  = 2'd1,
    SRV_PED = 2'd2
  } served_t;

  // Round-robin pick out of ALL_RED: scan NS -> EW -> PED -> NS, starting
  // with the phase after the last-served one. Nothing pending rests in NS.
  function automatic state_t rr_pick(input served_t last, input logic p_ns,
                                     input logic p_ew, input logic p_ped);
    state_t pick;
    pick = NS_GREEN;
    case (last)
      SRV_NS: begin
        if (p_ew)       pick = EW_GREEN;
        else if (p_ped) pick = PED_WALK;
        else if (p_ns)  pick = NS_GREEN;
      end
      SRV_EW: begin
        if (p_ped)      pick = PED_WALK;
        else if (p_ns)  pick = NS_GREEN;
        else if (p_ew)  pick = EW_GREEN;
      end
      default: begin
        if (p_ns)       pick = NS_GREEN;
        else if (p_ew)  pick = EW_GREEN;
        else if (p_ped) pick = PED_WALK;
      end
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating up-counter measuring cycles spent in the current phase.
// Latency: count reflects clr/increment one cycle after the edge; 0 the cycle after clr.
// Backpressure: none; counts every cycle, holds at all-ones.
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset, forces count to 0
//   clr   - synchronous clear (state entry); wins over increment
//   count - current cycle count within the phase
module phase_timer
  import intersection_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Traffic-light phase scheduler: NS/EW vehicle greens and a pedestrian walk, round-robin.
// Latency: requests latch into pending bits one cycle after the sensor; lamps are Moore (registered state).
// Backpressure: none; sensors are sampled every cycle and remembered until their phase is entered.
//
// Ports:
//   clk, rst                      - system clock, asynchronous active-high reset
//   ns_req, ew_req                - vehicle sensors (level)
//   ped_req                       - pedestrian button (level or one-cycle pulse)
//   NS_Red/Yellow/Green           - north-south lamp drives
//   EW_Red/Yellow/Green           - east-west lamp drives
//   walk                          - pedestrian walk lamp
//   phase                         - encoded current state
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
  parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
  parameter int unsigned ALL_RED_T = DEF_ALL_RED_T,
  parameter int unsigned WALK_T    = DEF_WALK_T
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ns_req,
  input  logic               ew_req,
  input  logic               ped_req,
  output logic               NS_Red,
  output logic               NS_Yellow,
  output logic               NS_Green,
  output logic               EW_Red,
  output logic               EW_Yellow,
  output logic               EW_Green,
  output logic               walk,
  output logic [PHASE_W-1:0] phase
);

  // Exit thresholds expressed as the timer value of the last cycle in phase
  localparam logic [TIMER_W-1:0] MIN_LIM  = 8'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_LIM  = 8'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_LIM  = 8'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] AR_LIM   = 8'(ALL_RED_T - 1);
  localparam logic [TIMER_W-1:0] WALK_LIM = 8'(WALK_T - 1);

  state_t              state;
  state_t              state_nxt;
  served_t             last_srv;
  logic                pend_ns;
  logic                pend_ew;
  logic                pend_ped;
  logic [TIMER_W-1:0]  timer;
  logic                state_entry;
  logic                enter_ns;
  logic                enter_ew;
  logic                enter_ped;

  // Any state change restarts the phase timer at 0 for the new state
  assign state_entry = (state_nxt != state);
  assign enter_ns    = state_entry && (state_nxt == NS_GREEN);
  assign enter_ew    = state_entry && (state_nxt == EW_GREEN);
  assign enter_ped   = state_entry && (state_nxt == PED_WALK);

  phase_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_entry),
    .count (timer)
  );

  // Next-state logic. Greens only ever hand over to their own yellow;
  // every route into a green or the walk goes through ALL_RED.
  always_comb begin
    state_nxt = state;
    case (state)
      NS_GREEN: begin
        if ((pend_ew || pend_ped) &&
            ((timer >= MAX_LIM) || ((timer >= MIN_LIM) && !ns_req))) begin
          state_nxt = NS_YELLOW;
        end
      end
      NS_YELLOW: begin
        if (timer == YEL_LIM) state_nxt = ALL_RED;
      end
      EW_GREEN: begin
        if ((pend_ns || pend_ped) &&
            ((timer >= MAX_LIM) || ((timer >= MIN_LIM) && !ew_req))) begin
          state_nxt = EW_YELLOW;
        end
      end
      EW_YELLOW: begin
        if (timer == YEL_LIM) state_nxt = ALL_RED;
      end
      PED_WALK: begin
        if (timer == WALK_LIM) state_nxt = ALL_RED;
      end
      ALL_RED: begin
        if (timer == AR_LIM) state_nxt = rr_pick(last_srv, pend_ns, pend_ew, pend_ped);
      end
      // Encodings 6/7 are illegal; recover through clearance
      default: state_nxt = ALL_RED;
    endcase
  end

  // State, pending requests and last-served bookkeeping. Entering a phase
  // clears its pending bit even if the sensor is high on that same cycle;
  // a request for the phase already being served is not remembered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= NS_GREEN;
      pend_ns  <= 1'b0;
      pend_ew  <= 1'b0;
      pend_ped <= 1'b0;
      last_srv <= SRV_PED;
    end else begin
      state    <= state_nxt;
      pend_ns  <= enter_ns  ? 1'b0 : (pend_ns  || (ns_req  && (state != NS_GREEN)));
      pend_ew  <= enter_ew  ? 1'b0 : (pend_ew  || (ew_req  && (state != EW_GREEN)));
      pend_ped <= enter_ped ? 1'b0 : (pend_ped || (ped_req && (state != PED_WALK)));
      if (enter_ns)       last_srv <= SRV_NS;
      else if (enter_ew)  last_srv <= SRV_EW;
      else if (enter_ped) last_srv <= SRV_PED;
    end
  end

  // Moore lamp decode; unknown encodings show all red
  always_comb begin
    NS_Red    = 1'b1;
    NS_Yellow = 1'b0;
    NS_Green  = 1'b0;
    EW_Red    = 1'b1;
    EW_Yellow = 1'b0;
    EW_Green  = 1'b0;
    walk      = 1'b0;
    case (state)
      NS_GREEN:  begin NS_Red = 1'b0; NS_Green  = 1'b1; end
      NS_YELLOW: begin NS_Red = 1'b0; NS_Yellow = 1'b1; end
      EW_GREEN:  begin EW_Red = 1'b0; EW_Green  = 1'b1; end
      EW_YELLOW: begin EW_Red = 1'b0; EW_Yellow = 1'b1; end
      PED_WALK:  walk = 1'b1;
      default:   ;
    endcase
  end

  assign phase = state;

endmodule
